// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst-lock FIFO arbiter.
package fifo_rr_arbiter_pkg;

  typedef enum logic {
    ArbIdle,
    ArbLocked
  } arb_state_e;

  // Widest requester vector rr_pick can handle.
  localparam int unsigned RrMaxReq = 32;
  localparam int unsigned RrIdxW   = 5;

  // One-hot of the first set bit of req at or after ptr, wrapping modulo num.
  function automatic logic [RrMaxReq-1:0] rr_pick(input logic [RrMaxReq-1:0] req,
                                                  input int unsigned         ptr,
                                                  input int unsigned         num);
    logic [RrMaxReq-1:0] gnt;
    logic                found;
    int unsigned         r;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < num; k++) begin
      r = (ptr + k) % num;
      if (!found && req[r[RrIdxW-1:0]]) begin
        gnt[r[RrIdxW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ_P = 4
) (
  input  logic [NUM_REQ_P-1:0]         req,
  input  logic [$clog2(NUM_REQ_P)-1:0] ptr,
  output logic [NUM_REQ_P-1:0]         gnt,
  output logic [$clog2(NUM_REQ_P)-1:0] idx,
  output logic                         any
);

  localparam int unsigned IdxW = $clog2(NUM_REQ_P);

  logic [NUM_REQ_P-1:0] rot;
  logic [IdxW-1:0]      first;

  assign any = |req;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot   = '0;
    first = '0;
    idx   = '0;
    gnt   = '0;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      rot[i] = req[IdxW'((i + int'(ptr)) % NUM_REQ_P)];
    end
    for (int i = NUM_REQ_P - 1; i >= 0; i--) begin
      if (rot[i]) first = IdxW'(i);
    end
    idx = IdxW'((int'(first) + int'(ptr)) % NUM_REQ_P);
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter with burst lock sharing one valid/ready FIFO input.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ_P   = 4,
  parameter int unsigned WIDTH_P     = 8,
  parameter int unsigned MAX_BURST_P = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ_P*WIDTH_P-1:0]   data_i,
  input  logic [NUM_REQ_P-1:0]           valid_i,
  input  logic [NUM_REQ_P-1:0]           last_i,
  output logic [NUM_REQ_P-1:0]           ready_o,
  output logic [WIDTH_P-1:0]             data_o,
  output logic                           valid_o,
  output logic                           last_o,
  input  logic                           ready_i,
  output logic [NUM_REQ_P-1:0]           grant_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ_P);
  // One spare count value so the forced release can fire without wrapping.
  localparam int unsigned CntW = $clog2(MAX_BURST_P + 1);

  arb_state_e           state_q;
  logic [IdxW-1:0]      rr_ptr_q;
  logic [IdxW-1:0]      gidx_q;
  logic [NUM_REQ_P-1:0] grant_q;
  logic [CntW-1:0]      beat_cnt_q;

  logic [NUM_REQ_P-1:0] pick_gnt;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic                 cnt_at_max;
  logic                 xfer;
  logic [IdxW-1:0]      next_ptr;

  rr_priority_picker #(
    .NUM_REQ_P(NUM_REQ_P)
  ) u_picker (
    .req(valid_i),
    .ptr(rr_ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign cnt_at_max = (beat_cnt_q == CntW'(MAX_BURST_P - 1));
  assign next_ptr   = (gidx_q == IdxW'(NUM_REQ_P - 1)) ? '0 : gidx_q + 1'b1;
  assign xfer       = valid_o & ready_i;
  assign grant_o    = grant_q;

  // Combinational datapath: route the owner's stream through, everything quiet when idle.
  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    ready_o = '0;
    if (state_q == ArbLocked) begin
      data_o  = data_i[int'(gidx_q)*WIDTH_P +: WIDTH_P];
      valid_o = valid_i[gidx_q];
      last_o  = valid_i[gidx_q] & (last_i[gidx_q] | cnt_at_max);
      ready_o = grant_q & {NUM_REQ_P{ready_i}};
    end
  end

  // Arbitration FSM: pick in IDLE, hold the grant until a last beat transfers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ArbIdle;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          if (pick_any) begin
            state_q    <= ArbLocked;
            grant_q    <= pick_gnt;
            gidx_q     <= pick_idx;
            beat_cnt_q <= '0;
          end
        end
        ArbLocked: begin
          if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_o) begin
              state_q  <= ArbIdle;
              grant_q  <= '0;
              rr_ptr_q <= next_ptr;
            end
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

endmodule
